// File: rtl/mac_pkg.sv
// Shared types and constants for the MAC operand sequencer and its FIFO.
package mac_pkg;

    // Operand width of the downstream MAC.
    localparam int DEFAULT_DATA_WIDTH = 8;

    // Pipeline depth of the downstream MAC. The sequencer uses it as the
    // number of zero-operand flush cycles after the last real pair.
    localparam int MAC_PIPE_DEPTH = 3;

    // Sequencer job phases.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } mac_state_e;

endpackage

// File: rtl/mac_operand_fifo.sv
// Small synchronous FIFO that holds packed {b, c} operand pairs.
// A push into a full FIFO and a pop from an empty FIFO are both ignored.
module mac_operand_fifo #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W-1:0] rd_ptr_q;
    logic [CNT_W-1:0] count_q;
    logic             do_push;
    logic             do_pop;

    assign full    = (count_q == CNT_W'(DEPTH));
    assign empty   = (count_q == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rdata   = mem_q[rd_ptr_q];

    // Storage array; contents are only meaningful between the pointers, so it needs no reset.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= wdata;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two; count tracks occupancy 0..DEPTH.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + CNT_W'(1);
                2'b01:   count_q <= count_q - CNT_W'(1);
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: rtl/mac_operand_sequencer.sv
// Feeds one dot-product job of vec_len operand pairs into the pipelined MAC,
// flushes the MAC pipeline with zero operands, then pulses done.
//
// Input handshake: a pair (in_b, in_c) is transferred on a rising clk edge
// where in_valid && in_ready are both high. in_ready depends only on the
// FIFO being not full (never on in_valid or on a same-cycle pop); the source
// must hold in_valid and its data stable until the transfer happens.
module mac_operand_sequencer
    import mac_pkg::*;
#(
    parameter int DATA_WIDTH   = DEFAULT_DATA_WIDTH,
    parameter int FIFO_DEPTH   = 4,
    parameter int LEN_WIDTH    = 8,
    parameter int DRAIN_CYCLES = MAC_PIPE_DEPTH
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [LEN_WIDTH-1:0]  vec_len,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] in_b,
    input  logic [DATA_WIDTH-1:0] in_c,
    output logic                  mac_enable,
    output logic [DATA_WIDTH-1:0] mac_b,
    output logic [DATA_WIDTH-1:0] mac_c,
    output logic                  busy,
    output logic                  done,
    output logic [LEN_WIDTH-1:0]  zero_skip_cnt,
    output mac_state_e            dbg_state
);

    localparam int DRAIN_W = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES + 1) : 1;

    // FIFO interface
    logic                    fifo_full;
    logic                    fifo_empty;
    logic                    fifo_pop;
    logic [2*DATA_WIDTH-1:0] fifo_rdata;
    logic [DATA_WIDTH-1:0]   pop_b;
    logic [DATA_WIDTH-1:0]   pop_c;

    // FSM and counters
    mac_state_e            state_q,     state_d;
    logic [LEN_WIDTH-1:0]  vec_len_q,   vec_len_d;
    logic [LEN_WIDTH-1:0]  issue_cnt_q, issue_cnt_d;
    logic [DRAIN_W-1:0]    drain_cnt_q, drain_cnt_d;
    logic [LEN_WIDTH-1:0]  zsc_q,       zsc_d;

    // Registered MAC-side outputs
    logic                  mac_en_q, mac_en_d;
    logic [DATA_WIDTH-1:0] mac_b_q,  mac_b_d;
    logic [DATA_WIDTH-1:0] mac_c_q,  mac_c_d;
    logic                  done_q,   done_d;

    mac_operand_fifo #(
        .WIDTH (2 * DATA_WIDTH),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (in_valid),
        .pop   (fifo_pop),
        .wdata ({in_b, in_c}),
        .rdata (fifo_rdata),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    assign in_ready = !fifo_full;
    // Pairs only leave the FIFO while a job is issuing; leftovers wait for the next job.
    assign fifo_pop = (state_q == ST_RUN) && !fifo_empty;
    assign pop_b    = fifo_rdata[2*DATA_WIDTH-1:DATA_WIDTH];
    assign pop_c    = fifo_rdata[DATA_WIDTH-1:0];

    assign mac_enable    = mac_en_q;
    assign mac_b         = mac_b_q;
    assign mac_c         = mac_c_q;
    assign done          = done_q;
    assign busy          = (state_q != ST_IDLE);
    assign zero_skip_cnt = zsc_q;
    assign dbg_state     = state_q;

    // Next-state, counter and MAC-output logic for the job sequence.
    always_comb begin
        state_d     = state_q;
        vec_len_d   = vec_len_q;
        issue_cnt_d = issue_cnt_q;
        drain_cnt_d = drain_cnt_q;
        zsc_d       = zsc_q;
        mac_en_d    = 1'b0;
        mac_b_d     = mac_b_q;
        mac_c_d     = mac_c_q;
        done_d      = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    if (vec_len != '0) begin
                        vec_len_d   = vec_len;
                        issue_cnt_d = '0;
                        zsc_d       = '0;
                        state_d     = ST_RUN;
                    end else begin
                        // Empty job: nothing to issue or flush, report completion directly.
                        state_d = ST_DONE;
                    end
                end
            end

            ST_RUN: begin
                // With an empty FIFO the MAC is simply not enabled and b/c keep their values.
                if (fifo_pop) begin
                    mac_en_d    = 1'b1;
                    mac_b_d     = pop_b;
                    mac_c_d     = pop_c;
                    issue_cnt_d = issue_cnt_q + LEN_WIDTH'(1);
                    if (((pop_b == '0) || (pop_c == '0)) && (zsc_q != '1)) begin
                        zsc_d = zsc_q + LEN_WIDTH'(1);
                    end
                    if (issue_cnt_q + LEN_WIDTH'(1) == vec_len_q) begin
                        drain_cnt_d = '0;
                        state_d     = ST_DRAIN;
                    end
                end
            end

            ST_DRAIN: begin
                // Enabled zero operands push the last real product through the MAC pipeline.
                mac_en_d = 1'b1;
                mac_b_d  = '0;
                mac_c_d  = '0;
                if (drain_cnt_q == DRAIN_W'(DRAIN_CYCLES - 1)) begin
                    state_d = ST_DONE;
                end else begin
                    drain_cnt_d = drain_cnt_q + DRAIN_W'(1);
                end
            end

            ST_DONE: begin
                done_d  = 1'b1;
                state_d = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State, counters and registered outputs; reset clears everything mid-job too.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            vec_len_q   <= '0;
            issue_cnt_q <= '0;
            drain_cnt_q <= '0;
            zsc_q       <= '0;
            mac_en_q    <= 1'b0;
            mac_b_q     <= '0;
            mac_c_q     <= '0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            vec_len_q   <= vec_len_d;
            issue_cnt_q <= issue_cnt_d;
            drain_cnt_q <= drain_cnt_d;
            zsc_q       <= zsc_d;
            mac_en_q    <= mac_en_d;
            mac_b_q     <= mac_b_d;
            mac_c_q     <= mac_c_d;
            done_q      <= done_d;
        end
    end

endmodule

// File: tb/tb_mac_operand_sequencer.sv
// Self-checking bench for mac_operand_sequencer: table of directed jobs,
// hand-written corner sequences and a randomized run against a queue model.
module tb_mac_operand_sequencer;
    import mac_pkg::*;

    localparam int DW    = 8;
    localparam int DEPTH = 4;
    localparam int LW    = 8;
    localparam int DRAIN = 3;

    // ---------------- clock / reset / DUT ----------------
    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic [LW-1:0] vec_len = '0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [DW-1:0] in_b = '0;
    logic [DW-1:0] in_c = '0;
    logic          mac_enable;
    logic [DW-1:0] mac_b;
    logic [DW-1:0] mac_c;
    logic          busy;
    logic          done;
    logic [LW-1:0] zero_skip_cnt;
    mac_state_e    dbg_state;

    always #5 clk = ~clk;

    mac_operand_sequencer #(
        .DATA_WIDTH(DW), .FIFO_DEPTH(DEPTH), .LEN_WIDTH(LW), .DRAIN_CYCLES(DRAIN)
    ) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .vec_len(vec_len),
        .in_valid(in_valid), .in_ready(in_ready), .in_b(in_b), .in_c(in_c),
        .mac_enable(mac_enable), .mac_b(mac_b), .mac_c(mac_c),
        .busy(busy), .done(done), .zero_skip_cnt(zero_skip_cnt), .dbg_state(dbg_state)
    );

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- bookkeeping ----------------
    int n_cmp = 0;
    int n_err = 0;
    int cyc   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // ---------------- source (driver) ----------------
    logic [15:0] src_q[$];   // pairs waiting at the source, {b, c}
    bit          feed_en = 1'b0;

    // ---------------- reference model ----------------
    // exp_q holds pairs accepted into the FIFO in order; they must be issued in this order.
    logic [15:0] exp_q[$];
    bit          m_active;
    int          m_left;
    int          m_drain;
    int          m_zsc;
    bit          m_en;
    logic [7:0]  m_b, m_c;
    bit          m_done;

    function automatic void model_reset();
        exp_q.delete();
        m_active = 0; m_left = 0; m_drain = 0; m_zsc = 0;
        m_en = 0; m_b = 0; m_c = 0; m_done = 0;
    endfunction

    // Advance the model over one rising edge using the inputs driven this cycle.
    function automatic void model_edge();
        bit          acc;
        logic [15:0] p;
        acc    = in_valid && (exp_q.size() < DEPTH);
        m_done = 0;
        if (!m_active) begin
            m_en = 0;
            if (start) begin
                m_active = 1;
                m_left   = int'(vec_len);
                m_drain  = (vec_len == 0) ? 0 : DRAIN;
                if (vec_len != 0) m_zsc = 0;
            end
        end else if (m_left > 0) begin
            if (exp_q.size() > 0) begin
                p    = exp_q.pop_front();
                m_en = 1; m_b = p[15:8]; m_c = p[7:0];
                if ((m_b == 0 || m_c == 0) && m_zsc < 255) m_zsc++;
                m_left--;
            end else begin
                m_en = 0;
            end
        end else if (m_drain > 0) begin
            m_en = 1; m_b = 0; m_c = 0;
            m_drain--;
        end else begin
            m_en = 0; m_done = 1; m_active = 0;
        end
        if (acc) exp_q.push_back({in_b, in_c});
    endfunction

    // ---------------- monitors ----------------
    int job_t0;
    int mon_sum, mon_en, mon_done_cnt, mon_done_cyc, mon_zsc;

    function automatic void mon_clear();
        job_t0 = cyc; mon_sum = 0; mon_en = 0; mon_done_cnt = 0; mon_done_cyc = -1; mon_zsc = -1;
    endfunction

    task automatic check_outputs();
        chk("in_ready", {31'd0, in_ready}, {31'd0, exp_q.size() < DEPTH});
        chk("busy", {31'd0, busy}, {31'd0, m_active});
        chk("mac_enable", {31'd0, mac_enable}, {31'd0, m_en});
        chk("mac_b", {24'd0, mac_b}, {24'd0, m_b});
        chk("mac_c", {24'd0, mac_c}, {24'd0, m_c});
        chk("done", {31'd0, done}, {31'd0, m_done});
        chk("zero_skip_cnt", {24'd0, zero_skip_cnt}, m_zsc);
        if (mac_enable === 1'b1) begin
            mon_en++;
            mon_sum += int'(mac_b) * int'(mac_c);
        end
        if (done === 1'b1) begin
            mon_done_cnt++;
            mon_done_cyc = cyc - job_t0;
            mon_zsc      = int'(zero_skip_cnt);
        end
    endtask

    // One clock cycle: drive source, check outputs, step model, advance to next edge.
    task automatic tick();
        bit acc;
        in_valid = feed_en && (src_q.size() > 0);
        if (in_valid) {in_b, in_c} = src_q[0];
        check_outputs();
        acc = in_valid && in_ready;
        model_edge();
        @(posedge clk); #1;
        cyc++;
        if (acc) void'(src_q.pop_front());
    endtask

    task automatic do_reset();
        rst_n = 1'b0; start = 1'b0; feed_en = 1'b0; in_valid = 1'b0;
        model_reset();
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst_n = 1'b1;
        cyc += 2;
    endtask

    task automatic prefill(input int n);
        feed_en = 1'b1;
        repeat (n) tick();
        feed_en = 1'b0;
        tick();
    endtask

    // Start a job at job cycle 0 and run until done is seen or the budget runs out.
    task automatic run_job(input int vl, input int feed_start, input int budget,
                           input int restart_a, input int restart_b);
        mon_clear();
        for (int t = 0; t < budget; t++) begin
            start   = (t == 0) || (t == restart_a) || (t == restart_b);
            vec_len = LW'(vl);
            feed_en = (t >= feed_start);
            tick();
            if (mon_done_cnt != 0) break;
        end
        start = 1'b0; feed_en = 1'b0;
    endtask

    // ---------------- directed vector table ----------------
    typedef struct {
        int          vl;
        int          npre;
        int          npairs;
        int          feed_start;
        logic [15:0] p [8];
        int          exp_done;
        int          exp_sum;
        int          exp_en;
        int          exp_zsc;
    } job_vec_t;

    job_vec_t vecs [5];

    function automatic logic [15:0] rand_pair();
        logic [7:0] b, c;
        b = ($urandom_range(0, 3) == 0) ? 8'd0 : 8'($urandom_range(1, 255));
        c = ($urandom_range(0, 3) == 0) ? 8'd0 : 8'($urandom_range(1, 255));
        return {b, c};
    endfunction

    initial begin
        vecs[0] = '{vl:4, npre:4, npairs:4, feed_start:99,
                    p:'{16'h0305, 16'h0007, 16'h0202, 16'h0400, 16'h0, 16'h0, 16'h0, 16'h0},
                    exp_done:9, exp_sum:19, exp_en:7, exp_zsc:2};
        vecs[1] = '{vl:4, npre:2, npairs:4, feed_start:5,
                    p:'{16'h0305, 16'h0007, 16'h0202, 16'h0400, 16'h0, 16'h0, 16'h0, 16'h0},
                    exp_done:12, exp_sum:19, exp_en:7, exp_zsc:2};
        vecs[2] = '{vl:0, npre:2, npairs:2, feed_start:99,
                    p:'{16'h0305, 16'h0007, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0},
                    exp_done:2, exp_sum:0, exp_en:0, exp_zsc:0};
        vecs[3] = '{vl:6, npre:4, npairs:6, feed_start:0,
                    p:'{16'h0101, 16'h0000, 16'h0900, 16'h0708, 16'h0003, 16'h0A0A, 16'h0, 16'h0},
                    exp_done:11, exp_sum:157, exp_en:9, exp_zsc:3};
        vecs[4] = '{vl:1, npre:1, npairs:1, feed_start:99,
                    p:'{16'hFFFF, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0},
                    exp_done:6, exp_sum:65025, exp_en:4, exp_zsc:0};

        model_reset();
        do_reset();
        // Reset state is checked by the first tick's output comparison.

        for (int i = 0; i < 5; i++) begin
            do_reset();
            src_q.delete();
            for (int k = 0; k < vecs[i].npairs; k++) src_q.push_back(vecs[i].p[k]);
            prefill(vecs[i].npre);
            run_job(vecs[i].vl, vecs[i].feed_start, 60, -1, -1);
            chk($sformatf("vec%0d_done_cycle", i), mon_done_cyc, vecs[i].exp_done);
            chk($sformatf("vec%0d_sum", i), mon_sum, vecs[i].exp_sum);
            chk($sformatf("vec%0d_enables", i), mon_en, vecs[i].exp_en);
            chk($sformatf("vec%0d_zsc", i), mon_zsc, vecs[i].exp_zsc);
            if (i == 2) begin
                // The empty job must leave the two queued pairs for this follow-up job.
                run_job(2, 99, 40, -1, -1);
                chk("after_len0_done_cycle", mon_done_cyc, 7);
                chk("after_len0_sum", mon_sum, 15);
                chk("after_len0_zsc", mon_zsc, 1);
            end
        end

        // FIFO fills at 4 entries; the 5th pair waits at the source.
        do_reset();
        src_q.delete();
        src_q = '{16'h0102, 16'h0304, 16'h0506, 16'h0708, 16'h090A};
        feed_en = 1'b1;
        repeat (6) tick();
        feed_en = 1'b0;
        chk("full_in_ready", {31'd0, in_ready}, 0);
        chk("full_src_left", src_q.size(), 1);
        run_job(2, 0, 40, -1, -1);
        chk("partial_done_cycle", mon_done_cyc, 7);
        chk("partial_sum", mon_sum, 14);
        chk("partial_src_left", src_q.size(), 0);
        run_job(3, 99, 40, -1, -1);
        chk("leftover_sum", mon_sum, 176);

        // Asynchronous reset in the middle of the drain phase.
        do_reset();
        src_q.delete();
        for (int k = 0; k < 4; k++) src_q.push_back(vecs[0].p[k]);
        prefill(4);
        run_job(4, 99, 7, -1, -1);
        chk("pre_reset_busy", {31'd0, busy}, 1);
        #2 rst_n = 1'b0;
        #1;
        chk("rst_mac_enable", {31'd0, mac_enable}, 0);
        chk("rst_busy", {31'd0, busy}, 0);
        chk("rst_zsc", {24'd0, zero_skip_cnt}, 0);
        chk("rst_mac_b", {24'd0, mac_b}, 0);
        chk("rst_in_ready", {31'd0, in_ready}, 1);
        model_reset();
        src_q.delete();
        start = 1'b0; feed_en = 1'b0; in_valid = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        cyc++;
        src_q = '{16'h0607, 16'h0009};
        run_job(2, 3, 40, -1, -1);
        chk("post_rst_done_cycle", mon_done_cyc, 10);
        chk("post_rst_sum", mon_sum, 42);
        chk("post_rst_zsc", mon_zsc, 1);

        // start re-pulsed during RUN and during DONE is ignored.
        do_reset();
        src_q.delete();
        for (int k = 0; k < 4; k++) src_q.push_back(vecs[0].p[k]);
        prefill(4);
        run_job(4, 99, 40, 3, 8);
        repeat (5) tick();
        chk("restart_done_cycle", mon_done_cyc, 9);
        chk("restart_done_pulses", mon_done_cnt, 1);
        chk("restart_enables", mon_en, 7);
        chk("restart_sum", mon_sum, 19);

        // Randomized traffic against the queue model.
        do_reset();
        src_q.delete();
        for (int i = 0; i < 2000; i++) begin
            if (src_q.size() < 3) src_q.push_back(rand_pair());
            feed_en = ($urandom_range(0, 9) < 7);
            start   = ($urandom_range(0, 7) == 0);
            vec_len = LW'($urandom_range(0, 9));
            if ($urandom_range(0, 399) == 0) do_reset();
            else tick();
        end
        start = 1'b0; feed_en = 1'b0;
        repeat (3) tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/mac_operand_sequencer.md
Name: mac_operand_sequencer

Overview:
- Upstream feeder for the pipelined data-aware MAC.
- Buffers incoming operand pairs (b, c) in a small FIFO using a valid/ready handshake.
- Issues exactly vec_len pairs to the MAC as one dot-product job, then runs zero-operand drain cycles to flush the MAC's 3-stage pipeline.
- Pulses done when mac_out holds the final sum, and counts zero-operand pairs (gated multiplies) for power statistics.

Parameters:
- DATA_WIDTH, 8, operand width; must match the MAC.
- FIFO_DEPTH, 4, operand-pair FIFO entries (power of 2, >=2).
- LEN_WIDTH, 8, width of vec_len and zero_skip_cnt.
- DRAIN_CYCLES, 3, enabled zero-operand cycles after the last pair (MAC pipeline depth).

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  job start pulse; sampled in IDLE only.
- vec_len  in  LEN_WIDTH  pairs in the job; sampled with start.
- in_valid  in  1  operand pair valid.
- in_ready  out  1  FIFO can accept a pair.
- in_b  in  DATA_WIDTH  operand b.
- in_c  in  DATA_WIDTH  operand c.
- mac_enable  out  1  drives MAC enable (registered).
- mac_b  out  DATA_WIDTH  drives MAC b_in (registered).
- mac_c  out  DATA_WIDTH  drives MAC c_in (registered).
- busy  out  1  state != IDLE.
- done  out  1  one-cycle pulse (registered); MAC result is final.
- zero_skip_cnt  out  LEN_WIDTH  pairs issued in the current/last job with b==0 or c==0.

Behaviour:
- Reset (async, any time, including mid-job):
  - state=IDLE; FIFO emptied; issue counter, drain counter and zero_skip_cnt =0.
  - mac_enable=0, mac_b=0, mac_c=0, done=0; in_ready=1 after release.
- FIFO:
  - Push when in_valid && in_ready; in_ready = !full, independent of same-cycle pop.
  - Pop only in RUN when not empty.
  - Pointers wrap modulo FIFO_DEPTH; count spans 0..FIFO_DEPTH.
  - Push is accepted in every state, so pairs may be prefilled while IDLE.
- FSM states: IDLE, RUN, DRAIN, DONE.
- IDLE:
  - start && vec_len!=0: latch vec_len, clear issue counter and zero_skip_cnt, go to RUN.
  - start && vec_len==0: go to DONE (no issue, no drain).
  - start is ignored in every other state.
- RUN:
  - FIFO not empty: pop one pair; next cycle mac_enable=1 with that pair; issue count +1; zero_skip_cnt +1 if b==0 or c==0.
  - FIFO empty: next cycle mac_enable=0 (MAC stalls and holds state); mac_b/mac_c hold their values.
  - When the pop making issue count == vec_len occurs, go to DRAIN.
- DRAIN:
  - Lasts DRAIN_CYCLES cycles; each cycle registers mac_enable=1, mac_b=0, mac_c=0.
  - Drain cycles are not counted in zero_skip_cnt.
  - Then go to DONE.
- DONE: register done=1 (visible next cycle), mac_enable=0, go to IDLE.
- Latency:
  - Full FIFO, start at cycle 0: pairs appear on mac_* at cycles 2..vec_len+1.
  - Drain at cycles vec_len+2..vec_len+1+DRAIN_CYCLES.
  - done at vec_len+2+DRAIN_CYCLES; busy high cycles 1..vec_len+1+DRAIN_CYCLES.
- Width: zero_skip_cnt saturates at all-ones; it holds until the next accepted start.
- A FIFO pop never occurs outside RUN; surplus pairs stay queued for the next job.

Decomposition:
- Shared package mac_pkg:
  - FSM state enum (IDLE, RUN, DRAIN, DONE).
  - Default DATA_WIDTH.
  - MAC_PIPE_DEPTH=3 constant, used as the DRAIN_CYCLES default.
- One sub-module: mac_operand_fifo.
  - Parameterised width 2*DATA_WIDTH and FIFO_DEPTH; async active-low reset.
  - Ports: push, pop, wdata, rdata, full, empty.
- FSM, counters and output registers live in the top.

Test Plan:
1. Prefill 4 pairs (3,5),(0,7),(2,2),(4,0); start, vec_len=4 at cycle 0 -> mac_enable=1 cycles 2-5 with those pairs, zeros cycles 6-8, done pulse cycle 9, zero_skip_cnt=2; MAC model sums to 19.
2. Same job with in_valid low for 3 cycles after the second pair -> mac_enable=0 exactly 3 cycles mid-stream, no duplicate or dropped pair, final sum unchanged, done 3 cycles later.
3. start with vec_len=0 -> busy 1 cycle, done pulse at cycle 2, mac_enable never asserted, FIFO contents untouched.
4. Push 5 pairs into the FIFO_DEPTH=4 FIFO with no job -> in_ready=0 after the 4th push, 5th held by the source; start vec_len=2 -> 2 pops, remaining entries intact.
5. Assert rst_n=0 during DRAIN -> immediately mac_enable=0, busy=0, FIFO empty, zero_skip_cnt=0; a new job after release runs normally.
6. start pulsed again while busy -> ignored; exactly vec_len pairs issued and a single done pulse.
